// File: rtl/tia_playfield_sequencer.sv
// tia_playfield_sequencer: TIA horizontal timing and playfield bit sequencer.
// A 2-bit colour-clock phase and a 0..56 horizontal count produce the hphi1/hphi2
// strobes, horizontal blank, and the playfield bit index for each half-line.
// The right half can be mirrored using the reflect bit, which is latched at the
// centre of the line.
// Optional feature macro: TIA_PLAYFIELD_SEQ_HMOVE_BLANK_EN. When it is defined,
// the hmove port is present, and an HMOVE during blank extends hblank by eight
// colour clocks (until hcount 19).
// The CTRLPF reflect input is named ctrlpf_ref because "ref" is a reserved word.
module tia_playfield_sequencer (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rsync,
  input  logic       ctrlpf_ref,
`ifdef TIA_PLAYFIELD_SEQ_HMOVE_BLANK_EN
  input  logic       hmove,
`endif
  output logic       hphi1,
  output logic       hphi2,
  output logic [5:0] hcount,
  output logic       hblank,
  output logic       pf_active,
  output logic [4:0] pf_idx,
  output logic       right_half,
  output logic       line_end
);

  logic [1:0] phase;
  logic [5:0] hcnt;
  logic       ref_q;
  logic       last_phase;
  logic       blank_int;

  assign last_phase = (phase == 2'd3);

  // Phase/hcount counters, with the reflect latch taken at the end of hcount 36.
  // A resync clears the counters but leaves the latched reflect bit as it is.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      phase <= '0;
      hcnt  <= '0;
      ref_q <= 1'b0;
    end else if (rsync) begin
      phase <= '0;
      hcnt  <= '0;
    end else begin
      phase <= phase + 2'd1;
      if (last_phase) begin
        hcnt <= (hcnt == 6'd56) ? '0 : hcnt + 6'd1;
      end
      if (last_phase && hcnt == 6'd36) begin
        ref_q <= ctrlpf_ref;
      end
    end
  end

`ifdef TIA_PLAYFIELD_SEQ_HMOVE_BLANK_EN
  logic hmove_flag;

  // HMOVE during blank arms the extended blank for the rest of this line.
  always_ff @(posedge clk) begin
    if (!reset_n || rsync) begin
      hmove_flag <= 1'b0;
    end else if (last_phase && hcnt == 6'd56) begin
      hmove_flag <= 1'b0;
    end else if (hmove && hcnt < 6'd17) begin
      hmove_flag <= 1'b1;
    end
  end

  // Blank ends at hcount 19 instead of 17 while the HMOVE flag is set.
  always_comb begin
    blank_int = hmove_flag ? (hcnt < 6'd19) : (hcnt < 6'd17);
  end
`else
  // The blank covers the first 17 hcounts (68 colour clocks).
  always_comb begin
    blank_int = (hcnt < 6'd17);
  end
`endif

  // Output decode from state only.
  // Index arithmetic is mod 32 on hcnt[4:0]: 17, 37 and 56 reduce to 17, 5 and 24.
  always_comb begin
    hphi1      = (phase == 2'd1);
    hphi2      = last_phase;
    hcount     = hcnt;
    hblank     = blank_int;
    pf_active  = !blank_int;
    right_half = (hcnt >= 6'd37);
    line_end   = last_phase && (hcnt == 6'd56);
    pf_idx     = '0;
    if (!blank_int) begin
      if (hcnt < 6'd37) begin
        pf_idx = hcnt[4:0] - 5'd17;
      end else if (ref_q) begin
        pf_idx = 5'd24 - hcnt[4:0];
      end else begin
        pf_idx = hcnt[4:0] - 5'd5;
      end
    end
  end

endmodule
